// File: rtl/stepper_pkg.sv
// stepper_pkg -- shared definitions for the network stepper.
//   STATE_W        : width of the network state vector (net_state, net_next, init_state).
//   STEP_W_DEFAULT : default step counter width (network_stepper CNT_W).
//   fsm_state_e    : controller states IDLE / EVAL / CAPTURE / DONE.
//   snap_entry_t   : one snapshot record {step, state} at the default counter width.
//                    The stepper builds the same layout sized to its own CNT_W.
package stepper_pkg;

  localparam int STATE_W        = 8;
  localparam int STEP_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [STEP_W_DEFAULT-1:0] step;
    logic [STATE_W-1:0]        state;
  } snap_entry_t;

endpackage

// File: rtl/network_stepper_snap_fifo.sv
// snap_fifo -- synchronous first-word-fall-through FIFO for committed snapshots.
//   Parameters: DEPTH (power of two, >= 2), W (entry width in bits).
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO).
//   push, din : write request and data; a push while full is accepted only
//               when a pop happens in the same cycle.
//   pop       : read request; ignored while empty.
//   dout      : head entry, valid whenever empty is low.
//   full/empty: occupancy flags.
module snap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/network_stepper.sv
// network_stepper -- steps an external combinational/registered network_logic
// block for a programmed number of steps and streams every committed state
// out through a snapshot FIFO.
//   Parameters: FIFO_DEPTH (snapshot entries, power of two >= 2),
//               CNT_W (step counter width).
//   clk, rst            : clock, synchronous active-high reset.
//   init_state, load    : state register preload (IDLE only).
//   start, num_steps    : begin a run of num_steps steps (IDLE only).
//   abort               : drop back to IDLE, keeping last committed values.
//   net_state / net_next: current state to network_logic / its next state
//                         (one cycle of latency, covered by EVAL).
//   busy, done          : run in progress / one-cycle completion pulse.
//   step_count          : steps committed in the current or last run.
//   snap_valid/ready/data/step : snapshot stream (transfer when valid&ready).
// Optional feature, macro STEPPER_CONVERGE_EN: adds output converged and ends
// a run early when the network reaches a fixed point.
module network_stepper
  import stepper_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = STEP_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] init_state,
  input  logic               load,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_steps,
  input  logic               abort,
  output logic [STATE_W-1:0] net_state,
  input  logic [STATE_W-1:0] net_next,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   step_count,
  output logic               snap_valid,
  input  logic               snap_ready,
  output logic [STATE_W-1:0] snap_data,
  output logic [CNT_W-1:0]   snap_step
`ifdef STEPPER_CONVERGE_EN
  ,
  output logic               converged
`endif
);

  // Same layout as stepper_pkg::snap_entry_t, sized to this instance's CNT_W.
  typedef struct packed {
    logic [CNT_W-1:0]   step;
    logic [STATE_W-1:0] state;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  fsm_state_e         fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   nsteps_q, nsteps_d;
`ifdef STEPPER_CONVERGE_EN
  logic               conv_q, conv_d;
`endif

  logic [CNT_W-1:0]   step_inc;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             push_entry;
  entry_t             head_entry;

  // Wraps modulo 2^CNT_W; the end-of-run compare uses the full width.
  assign step_inc   = count_q + CNT_W'(1);
  assign fifo_pop   = snap_valid && snap_ready;
  assign push_entry = '{step: step_inc, state: net_next};

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    count_d   = count_q;
    nsteps_d  = nsteps_q;
    fifo_push = 1'b0;
    done      = 1'b0;
`ifdef STEPPER_CONVERGE_EN
    conv_d    = conv_q;
`endif
    unique case (fsm_q)
      ST_IDLE: begin
        // load applies first so a simultaneous start runs from the loaded state.
        if (load) state_d = init_state;
        if (start) begin
          count_d  = '0;
          nsteps_d = num_steps;
`ifdef STEPPER_CONVERGE_EN
          conv_d   = 1'b0;
`endif
          fsm_d    = (num_steps == '0) ? ST_DONE : ST_EVAL;
        end
      end
      ST_EVAL: begin
        fsm_d = abort ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort) begin
          fsm_d = ST_IDLE;
        end else if (!fifo_full || fifo_pop) begin
          // A pop this cycle frees a slot, so a full FIFO still accepts the push.
          fifo_push = 1'b1;
          state_d   = net_next;
          count_d   = step_inc;
          fsm_d     = (step_inc == nsteps_q) ? ST_DONE : ST_EVAL;
`ifdef STEPPER_CONVERGE_EN
          if (net_next == state_q) begin
            conv_d = 1'b1;
            fsm_d  = ST_DONE;
          end
`endif
        end
        // Otherwise stall: state, count and net_state hold until space appears.
      end
      ST_DONE: begin
        // An abort landing on the DONE cycle suppresses the pulse.
        done  = !abort;
        fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= ST_IDLE;
      state_q  <= '0;
      count_q  <= '0;
      nsteps_q <= '0;
`ifdef STEPPER_CONVERGE_EN
      conv_q   <= 1'b0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      count_q  <= count_d;
      nsteps_q <= nsteps_d;
`ifdef STEPPER_CONVERGE_EN
      conv_q   <= conv_d;
`endif
    end
  end

  snap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_snap_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy       = (fsm_q != ST_IDLE);
  assign net_state  = state_q;
  assign step_count = count_q;
  assign snap_valid = !fifo_empty;
  assign snap_data  = head_entry.state;
  assign snap_step  = head_entry.step;
`ifdef STEPPER_CONVERGE_EN
  assign converged  = conv_q;
`endif

endmodule

// File: tb/tb_network_stepper.sv
`timescale 1ns/1ps
module tb_network_stepper;
  import stepper_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   init_state;
  logic         load;
  logic         start;
  logic [15:0]  num_steps;
  logic         abort;
  logic [7:0]   net_state;
  logic [7:0]   net_next;
  logic         busy;
  logic         done;
  logic [15:0]  step_count;
  logic         snap_valid;
  logic         snap_ready;
  logic [7:0]   snap_data;
  logic [15:0]  snap_step;
`ifdef STEPPER_CONVERGE_EN
  logic         converged;
`endif

  always #5 clk = ~clk;

  network_stepper #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_state (init_state),
    .load       (load),
    .start      (start),
    .num_steps  (num_steps),
    .abort      (abort),
    .net_state  (net_state),
    .net_next   (net_next),
    .busy       (busy),
    .done       (done),
    .step_count (step_count),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_data  (snap_data),
    .snap_step  (snap_step)
`ifdef STEPPER_CONVERGE_EN
    ,
    .converged  (converged)
`endif
  );

  // Model of network_logic: rotate-left by one, registered (1-cycle latency).
  function automatic logic [7:0] rotl(input logic [7:0] s);
    return {s[6:0], s[7]};
  endfunction

  always @(posedge clk) net_next <= rotl(net_state);

  // Snapshot and done monitor, sampled mid-cycle.
  snap_entry_t got_q[$];
  int          done_seen = 0;
  always @(negedge clk) begin
    if (rst === 1'b0 && snap_valid && snap_ready) got_q.push_back({snap_step, snap_data});
    if (done === 1'b1) done_seen++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts posedges from the start edge until done is seen (start edge = 1).
  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_snaps(input string tag, input logic [7:0] s0, input int n);
    logic [7:0] s;
    s = s0;
    check({tag, "_nsnap"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      s = rotl(s);
      check({tag, "_step"}, got_q[i].step, i + 1);
      check({tag, "_data"}, got_q[i].state, s);
    end
  endtask

  typedef struct {
    bit         do_load;
    logic [7:0] init;
    logic [15:0] steps;
    logic [7:0] start_state;
    logic [7:0] exp_state;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int done_ref;

    vecs[0] = '{1'b1, 8'h01, 16'd5, 8'h01, 8'h20, 16'd5};
    vecs[1] = '{1'b0, 8'h81, 16'd0, 8'h20, 8'h20, 16'd0};
    vecs[2] = '{1'b1, 8'h81, 16'd3, 8'h81, 8'h0C, 16'd3};
    vecs[3] = '{1'b0, 8'h55, 16'd1, 8'h0C, 8'h18, 16'd1};
    vecs[4] = '{1'b1, 8'hC3, 16'd4, 8'hC3, 8'h3C, 16'd4};

    rst = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0;
    init_state = 8'h00; num_steps = 16'd0; snap_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_net_state", net_state, 0);
    check("rst_step_count", step_count, 0);
    check("rst_snap_valid", snap_valid, 0);
`ifdef STEPPER_CONVERGE_EN
    check("rst_converged", converged, 0);
`endif
    rst = 1'b0;
    tick();

    // Table-driven runs with the snapshot stream always ready.
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      snap_ready = 1'b1;
      init_state = vecs[v].init;
      load = vecs[v].do_load;
      num_steps = vecs[v].steps;
      start = 1'b1;
      tick();
      load = 1'b0; start = 1'b0;
      lat = 1;
      wait_done(lat);
      check("run_latency", lat, 2 * vecs[v].steps + 1);
      check("run_step_count", step_count, vecs[v].exp_count);
      check("run_net_state", net_state, vecs[v].exp_state);
      tick();
      check("run_done_pulse", done, 0);
      check("run_busy_after", busy, 0);
      repeat (3) tick();
      check_snaps("run", vecs[v].start_state, int'(vecs[v].steps));
      $display("vec %0d: steps=%0d latency=%0d snapshots=%0d state=0x%02h",
               v, vecs[v].steps, lat, got_q.size(), net_state);
    end

    // Backpressure: FIFO fills at step 4, run stalls, then drains in order.
    got_q.delete();
    snap_ready = 1'b0;
    init_state = 8'h01; load = 1'b1; num_steps = 16'd8; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    done_ref = done_seen;
    repeat (20) tick();
    check("stall_busy", busy, 1);
    check("stall_step_count", step_count, 4);
    check("stall_net_state", net_state, 8'h10);
    check("stall_snap_valid", snap_valid, 1);
    check("stall_no_done", done_seen, done_ref);
    snap_ready = 1'b1;
    lat = 0;
    wait_done(lat);
    check("stall_done_seen", done, 1);
    check("stall_final_count", step_count, 8);
    check("stall_final_state", net_state, 8'h01);
    repeat (4) tick();
    check_snaps("stall", 8'h01, 8);
    $display("stall run: snapshots=%0d step_count=%0d", got_q.size(), step_count);

    // Abort in EVAL of step 3.
    got_q.delete();
    init_state = 8'h01; load = 1'b1; num_steps = 16'd5; start = 1'b1;
    done_ref = done_seen;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_step_count", step_count, 2);
    check("abort_net_state", net_state, 8'h04);
    repeat (4) tick();
    check("abort_no_done", done_seen, done_ref);
    check_snaps("abort", 8'h01, 2);
    $display("abort run: snapshots=%0d step_count=%0d", got_q.size(), step_count);

    // load/start while busy are ignored.
    got_q.delete();
    init_state = 8'h01; load = 1'b1; num_steps = 16'd2; start = 1'b1;
    tick();
    init_state = 8'hAA; num_steps = 16'd7;
    tick();
    load = 1'b0; start = 1'b0;
    lat = 2;
    wait_done(lat);
    check("busy_load_latency", lat, 5);
    check("busy_load_state", net_state, 8'h04);
    check("busy_load_count", step_count, 2);
    repeat (3) tick();
    $display("busy load run: snapshots=%0d state=0x%02h", got_q.size(), net_state);

    // Reset while in CAPTURE of step 1 with the stream stalled.
    got_q.delete();
    snap_ready = 1'b0;
    init_state = 8'h01; load = 1'b1; num_steps = 16'd5; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    rst = 1'b1;
    done_ref = done_seen;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_step_count", step_count, 0);
    check("midrst_net_state", net_state, 0);
    check("midrst_snap_valid", snap_valid, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", done_seen, done_ref);
    check("midrst_idle", busy, 0);
    $display("mid-run reset: busy=%0d snap_valid=%0d", busy, snap_valid);

`ifdef STEPPER_CONVERGE_EN
    // Fixed point of the rotate network: 0xFF.
    got_q.delete();
    snap_ready = 1'b1;
    init_state = 8'hFF; load = 1'b1; num_steps = 16'd10; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    lat = 1;
    wait_done(lat);
    check("conv_latency", lat, 3);
    check("conv_flag", converged, 1);
    check("conv_step_count", step_count, 1);
    repeat (3) tick();
    check_snaps("conv", 8'hFF, 1);
    num_steps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("conv_cleared_on_start", converged, 0);
    repeat (4) tick();
    $display("converge run: snapshots=%0d", got_q.size());
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
